// File: rtl/msrv32_csr_file_if.sv
// CSR access bus between the stage-2 register and the CSR file.
// Carries address/op/operands in and the read data / illegal flag back.
interface msrv32_csr_file_if;
  logic [11:0] csr_addr_in;
  logic [2:0]  csr_op_in;
  logic        csr_wr_en_in;
  logic [31:0] rs1_in;
  logic [4:0]  csr_uimm_in;
  logic [31:0] csr_data_out;
  logic        illegal_csr_out;

  modport master (
    output csr_addr_in,
    output csr_op_in,
    output csr_wr_en_in,
    output rs1_in,
    output csr_uimm_in,
    input  csr_data_out,
    input  illegal_csr_out
  );

  modport slave (
    input  csr_addr_in,
    input  csr_op_in,
    input  csr_wr_en_in,
    input  rs1_in,
    input  csr_uimm_in,
    output csr_data_out,
    output illegal_csr_out
  );
endinterface

// File: rtl/msrv32_csr_file.sv
// Machine-mode CSR file: trap state, mtvec/mscratch, 64-bit counters.
// Ports: clk_in, reset_n_in (sync, active low), csr bus (slave),
// instret_in, trap_*_in, mret_in, trap_address_out, epc_out, mie_out.
// Counters exist only when MSRV32_CSR_COUNTERS_EN is defined.
module msrv32_csr_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MHARTID     = 32'h0000_0000
) (
  input  logic                     clk_in,
  input  logic                     reset_n_in,
  msrv32_csr_file_if.slave         csr,
  input  logic                     instret_in,
  input  logic                     trap_taken_in,
  input  logic [31:0]              trap_cause_in,
  input  logic [31:0]              trap_pc_in,
  input  logic [31:0]              trap_tval_in,
  input  logic                     mret_in,
  output logic [31:0]              trap_address_out,
  output logic [31:0]              epc_out,
  output logic                     mie_out
);

  logic        mie_q;
  logic        mpie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  logic [31:0] rdata;
  logic        mapped;
  logic [31:0] src;
  logic [31:0] new_val;
  logic        ro_addr;
  logic        wr_ok;
  logic [11:0] addr;

  assign addr = csr.csr_addr_in;

  always_comb begin
    rdata  = '0;
    mapped = 1'b1;
    unique case (addr)
      12'h300: rdata = {19'b0, 2'b11, 3'b0, mpie_q,
                        3'b0, mie_q, 3'b0};
      12'h301: rdata = 32'h4000_0100;
      12'h305: rdata = mtvec_q;
      12'h340: rdata = mscratch_q;
      12'h341: rdata = mepc_q;
      12'h342: rdata = mcause_q;
      12'h343: rdata = mtval_q;
      12'hB00: rdata = mcycle[31:0];
      12'hB02: rdata = minstret[31:0];
      12'hB80: rdata = mcycle[63:32];
      12'hB82: rdata = minstret[63:32];
      12'hF11,
      12'hF12,
      12'hF13: rdata = '0;
      12'hF14: rdata = MHARTID;
      default: mapped = 1'b0;
    endcase
  end

  assign csr.csr_data_out = rdata;

  assign src = csr.csr_op_in[2] ? {27'b0, csr.csr_uimm_in}
                                : csr.rs1_in;

  always_comb begin
    new_val = rdata;
    unique case (csr.csr_op_in[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = rdata | src;
      2'b11:   new_val = rdata & ~src;
      default: new_val = rdata;
    endcase
  end

  assign ro_addr = (addr[11:10] == 2'b11);

  assign csr.illegal_csr_out = csr.csr_wr_en_in
    & (~mapped | (ro_addr & (csr.csr_op_in[1:0] != 2'b00)));

  // A trap in the same cycle swallows the CSR write.
  assign wr_ok = csr.csr_wr_en_in
    & (csr.csr_op_in[1:0] != 2'b00)
    & mapped & ~ro_addr & ~trap_taken_in;

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET & ~32'h3;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      if (trap_taken_in) begin
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
        mepc_q   <= trap_pc_in & ~32'h3;
        mcause_q <= trap_cause_in;
        mtval_q  <= trap_tval_in;
      end else begin
        if (mret_in) begin
          mie_q  <= mpie_q;
          mpie_q <= 1'b1;
        end else if (wr_ok && addr == 12'h300) begin
          mie_q  <= new_val[3];
          mpie_q <= new_val[7];
        end
        if (wr_ok && addr == 12'h341)
          mepc_q <= new_val & ~32'h3;
        if (wr_ok && addr == 12'h342)
          mcause_q <= new_val;
        if (wr_ok && addr == 12'h343)
          mtval_q <= new_val;
      end
      if (wr_ok && addr == 12'h305)
        mtvec_q <= new_val & ~32'h3;
      if (wr_ok && addr == 12'h340)
        mscratch_q <= new_val;
    end
  end

`ifdef MSRV32_CSR_COUNTERS_EN
  logic [63:0] mcycle_q;
  logic [63:0] minstret_q;

  // A write to either half freezes the whole counter that cycle.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (wr_ok && addr == 12'hB00)
        mcycle_q[31:0] <= new_val;
      else if (wr_ok && addr == 12'hB80)
        mcycle_q[63:32] <= new_val;
      else
        mcycle_q <= mcycle_q + 64'd1;

      if (wr_ok && addr == 12'hB02)
        minstret_q[31:0] <= new_val;
      else if (wr_ok && addr == 12'hB82)
        minstret_q[63:32] <= new_val;
      else if (instret_in)
        minstret_q <= minstret_q + 64'd1;
    end
  end

  assign mcycle   = mcycle_q;
  assign minstret = minstret_q;
`else
  logic unused_instret;
  assign unused_instret = instret_in;
  assign mcycle   = '0;
  assign minstret = '0;
`endif

  assign trap_address_out = mtvec_q;
  assign epc_out          = mepc_q;
  assign mie_out          = mie_q;

endmodule
